// File: rtl/i2c_frame_receiver.sv
// rtl/i2c_frame_receiver.sv - I2C target front end for single-register write frames
module i2c_frame_receiver #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h40,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_SCL,
    input  logic       i_SDA,
    output logic       o_SDA_low,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_ADDR, REG, ACK_REG, DATA, ACK_DATA, WAIT_STOP, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, sda_prev_q;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] reg_byte_q, reg_byte_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       sda_low_q, sda_low_d;
    logic       ack_held_q, ack_held_d;

    logic       scl_s, sda_s;
    logic       start_ev, stop_ev, scl_rise, scl_fall;
    logic [7:0] byte_w;

    assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i_SCL};
    assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], i_SDA};
    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];

    assign start_ev = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_ev  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    assign byte_w   = {shift_q, sda_s};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        reg_byte_d = reg_byte_q;
        reg_addr_d = reg_addr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        sda_low_d  = sda_low_q;
        ack_held_d = ack_held_q;

        // Bus conditions override any SCL edge seen in the same cycle.
        if (start_ev) begin
            state_d    = ADDR;
            cnt_d      = 4'd0;
            sda_low_d  = 1'b0;
            ack_held_d = 1'b0;
        end else if (stop_ev) begin
            state_d    = IDLE;
            cnt_d      = 4'd0;
            sda_low_d  = 1'b0;
            ack_held_d = 1'b0;
        end else begin
            case (state_q)
                ADDR, REG, DATA: begin
                    if (scl_rise) begin
                        shift_d = byte_w[6:0];
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            case (state_q)
                                ADDR: begin
                                    if (byte_w[7:1] == SLAVE_ADDR && !byte_w[0]) begin
                                        state_d = ACK_ADDR;
                                    end else begin
                                        state_d = IGNORE;
                                    end
                                end
                                REG: begin
                                    reg_byte_d = byte_w;
                                    state_d    = ACK_REG;
                                end
                                default: begin
                                    reg_addr_d = reg_byte_q;
                                    data_d     = byte_w;
                                    valid_d    = 1'b1;
                                    state_d    = ACK_DATA;
                                end
                            endcase
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                ACK_ADDR, ACK_REG, ACK_DATA: begin
                    // First fall opens the ACK slot, the second fall closes it.
                    if (scl_fall) begin
                        if (!ack_held_q) begin
                            sda_low_d  = 1'b1;
                            ack_held_d = 1'b1;
                        end else begin
                            sda_low_d  = 1'b0;
                            ack_held_d = 1'b0;
                            case (state_q)
                                ACK_ADDR: state_d = REG;
                                ACK_REG:  state_d = DATA;
                                default:  state_d = WAIT_STOP;
                            endcase
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 7'd0;
            reg_byte_q <= 8'h00;
            reg_addr_q <= 8'h00;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            sda_low_q  <= 1'b0;
            ack_held_q <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            reg_byte_q <= reg_byte_d;
            reg_addr_q <= reg_addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sda_low_q  <= sda_low_d;
            ack_held_q <= ack_held_d;
        end
    end

    assign o_SDA_low  = sda_low_q;
    assign o_reg_addr = reg_addr_q;
    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_frame_receiver.sv
// tb/tb_i2c_frame_receiver.sv - directed bench for i2c_frame_receiver
module tb_i2c_frame_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       o_SDA_low;
    logic [7:0] o_reg_addr;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int valid_cnt = 0;
    int low_cnt = 0;
    logic [7:0] last_reg = 8'h00;
    logic [7:0] last_data = 8'h00;

    // Open-drain bus: either side can pull SDA low.
    assign sda_bus = sda_m & ~o_SDA_low;

    i2c_frame_receiver #(.SLAVE_ADDR(7'h40), .SYNC_STAGES(2)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_SCL      (scl_m),
        .i_SDA      (sda_bus),
        .o_SDA_low  (o_SDA_low),
        .o_reg_addr (o_reg_addr),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_valid) begin
            valid_cnt = valid_cnt + 1;
            last_reg  = o_reg_addr;
            last_data = o_data;
        end
        if (o_SDA_low) low_cnt = low_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b0;
        cyc(8);
        scl_m = 1'b0;
    endtask

    task automatic i2c_rstart();
        cyc(4); sda_m = 1'b1;
        cyc(4); scl_m = 1'b1;
        cyc(8); sda_m = 1'b0;
        cyc(8); scl_m = 1'b0;
    endtask

    // 16-cycle SCL period; sample the pad drive mid high phase.
    task automatic i2c_bit(input logic b, output logic low);
        cyc(4); sda_m = b;
        cyc(4); scl_m = 1'b1;
        cyc(4); low = o_SDA_low;
        cyc(4); scl_m = 1'b0;
    endtask

    task automatic i2c_byte(input logic [7:0] b, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], dummy);
        i2c_bit(1'b1, ack);
    endtask

    task automatic i2c_stop(output int lat);
        cyc(4); sda_m = 1'b0;
        cyc(4); scl_m = 1'b1;
        cyc(8); sda_m = 1'b1;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            lat++;
            if (!o_busy) break;
        end
        if (o_busy) lat = 99;
        cyc(8);
    endtask

    initial begin
        logic a1, a2, a3, dummy;
        int   lat, v0, l0;

        cyc(3);
        check_eq("rst_sda_low", o_SDA_low, 0);
        check_eq("rst_valid", o_valid, 0);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_reg_addr", o_reg_addr, 8'h00);
        check_eq("rst_data", o_data, 8'h00);
        rst = 1'b0;
        cyc(4);

        // Full write frame
        v0 = valid_cnt;
        i2c_start();
        i2c_byte(8'h80, a1);
        i2c_byte(8'h1A, a2);
        i2c_byte(8'hC3, a3);
        check_eq("t1_ack_addr", a1, 1);
        check_eq("t1_ack_reg", a2, 1);
        check_eq("t1_ack_data", a3, 1);
        check_eq("t1_busy_mid", o_busy, 1);
        i2c_stop(lat);
        check_eq("t1_busy_latency", lat, 3);
        check_eq("t1_valid_count", valid_cnt - v0, 1);
        check_eq("t1_valid_reg", last_reg, 8'h1A);
        check_eq("t1_valid_data", last_data, 8'hC3);
        check_eq("t1_hold_reg", o_reg_addr, 8'h1A);
        check_eq("t1_hold_data", o_data, 8'hC3);

        // Wrong address
        v0 = valid_cnt; l0 = low_cnt;
        i2c_start();
        i2c_byte(8'h82, a1);
        i2c_byte(8'h1A, a2);
        i2c_byte(8'hC3, a3);
        check_eq("t2_busy_mid", o_busy, 1);
        i2c_stop(lat);
        check_eq("t2_no_drive", low_cnt - l0, 0);
        check_eq("t2_no_valid", valid_cnt - v0, 0);
        check_eq("t2_busy_end", o_busy, 0);

        // Read bit
        v0 = valid_cnt; l0 = low_cnt;
        i2c_start();
        i2c_byte(8'h81, a1);
        i2c_byte(8'h1A, a2);
        i2c_stop(lat);
        check_eq("t3_no_ack", a1, 0);
        check_eq("t3_no_drive", low_cnt - l0, 0);
        check_eq("t3_no_valid", valid_cnt - v0, 0);

        // Truncated frame
        v0 = valid_cnt;
        i2c_start();
        i2c_byte(8'h80, a1);
        i2c_byte(8'h05, a2);
        i2c_stop(lat);
        check_eq("t4_ack_reg", a2, 1);
        check_eq("t4_no_valid", valid_cnt - v0, 0);
        check_eq("t4_keep_reg", o_reg_addr, 8'h1A);
        check_eq("t4_keep_data", o_data, 8'hC3);

        // Repeated start after reg byte
        v0 = valid_cnt;
        i2c_start();
        i2c_byte(8'h80, a1);
        i2c_byte(8'h05, a2);
        i2c_rstart();
        i2c_byte(8'h80, a1);
        i2c_byte(8'h22, a2);
        i2c_byte(8'h7E, a3);
        i2c_stop(lat);
        check_eq("t5_ack_addr", a1, 1);
        check_eq("t5_ack_reg", a2, 1);
        check_eq("t5_ack_data", a3, 1);
        check_eq("t5_valid_count", valid_cnt - v0, 1);
        check_eq("t5_reg", o_reg_addr, 8'h22);
        check_eq("t5_data", o_data, 8'h7E);

        // Reset in the 4th data bit
        v0 = valid_cnt;
        i2c_start();
        i2c_byte(8'h80, a1);
        i2c_byte(8'h33, a2);
        i2c_bit(1'b1, dummy);
        i2c_bit(1'b1, dummy);
        i2c_bit(1'b1, dummy);
        cyc(4); sda_m = 1'b1;
        cyc(4); scl_m = 1'b1;
        cyc(2);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_busy_async", o_busy, 0);
        check_eq("t6_reg_async", o_reg_addr, 8'h00);
        check_eq("t6_data_async", o_data, 8'h00);
        check_eq("t6_sda_low_async", o_SDA_low, 0);
        check_eq("t6_valid_async", o_valid, 0);
        cyc(2);
        rst = 1'b0;
        cyc(4); scl_m = 1'b0;
        for (int i = 0; i < 4; i++) i2c_bit(1'b0, dummy);
        i2c_bit(1'b1, dummy);
        i2c_stop(lat);
        check_eq("t6_cut_no_valid", valid_cnt - v0, 0);
        v0 = valid_cnt;
        i2c_start();
        i2c_byte(8'h80, a1);
        i2c_byte(8'h10, a2);
        i2c_byte(8'h01, a3);
        i2c_stop(lat);
        check_eq("t6_acks", {a1, a2, a3}, 3'b111);
        check_eq("t6_valid_count", valid_cnt - v0, 1);
        check_eq("t6_reg", o_reg_addr, 8'h10);
        check_eq("t6_data", o_data, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_frame_receiver.md
Name: i2c_frame_receiver

Overview:
- I2C target (slave) front end for the single-register write frame produced by the team's I2C frame transmitter.
- Frame format: START, 7-bit address + W bit, ACK, 8-bit register address, ACK, 8-bit data, ACK, STOP.
- Oversamples SCL/SDA on the system clock, ACKs a matching address, and presents {register address, data} to the register file with a one-cycle valid strobe.
- Sits between the board I2C pins (open-drain pad outside this block) and the local register bank.

Parameters:
- SLAVE_ADDR, 7'h40, 7-bit target address answered by this block.
- SYNC_STAGES, 2, synchronizer flops on i_SCL and i_SDA (minimum 2).

Ports:
- i_clk  input  1  system clock; must be at least 8x the SCL rate.
- i_rst  input  1  reset, asynchronous, active-high.
- i_SCL  input  1  I2C clock pin level.
- i_SDA  input  1  I2C data pin level.
- o_SDA_low  output  1  1 = pad pulls SDA low (ACK); 0 = release.
- o_reg_addr  output  8  received register address, held until next valid.
- o_data  output  8  received data byte, held until next valid.
- o_valid  output  1  one-cycle pulse when a complete write is captured.
- o_busy  output  1  high from START detect until STOP or return to IDLE.

Behaviour:
- Reset (async, i_rst=1):
  - Synchronizers preset to 1.
  - State = IDLE.
  - o_SDA_low=0, o_valid=0, o_busy=0, o_reg_addr=8'h00, o_data=8'h00.
- Sampling:
  - i_SCL and i_SDA pass through SYNC_STAGES flops, then one history flop for edge detect.
  - Pin edge to internal event latency = SYNC_STAGES+1 i_clk cycles.
- Events, evaluated on synchronized signals each cycle:
  - START: SDA falls while SCL=1.
  - STOP: SDA rises while SCL=1.
  - SCL_RISE / SCL_FALL: edges of SCL.
- Bit capture:
  - Data bits are shifted in MSB first on SCL_RISE.
  - A 4-bit counter counts 0..7 within each byte.
- States and transitions:
  - IDLE: wait for START -> ADDR; o_busy=1.
  - ADDR: capture 8 bits. After the 8th SCL_RISE:
    - If byte[7:1]==SLAVE_ADDR and byte[0]==0 -> ACK_ADDR.
    - Otherwise -> IGNORE (no ACK).
  - ACK_ADDR / ACK_REG / ACK_DATA:
    - On the first SCL_FALL, set o_SDA_low=1.
    - Hold through the following SCL_RISE.
    - On the next SCL_FALL, set o_SDA_low=0 and advance: ACK_ADDR -> REG, ACK_REG -> DATA, ACK_DATA -> WAIT_STOP.
  - REG: capture 8 bits; after the 8th rise -> ACK_REG.
  - DATA: capture 8 bits; after the 8th rise -> ACK_DATA.
    - In the same cycle: load o_reg_addr and o_data, and pulse o_valid for exactly 1 cycle.
  - WAIT_STOP / IGNORE: no SDA drive. Additional bytes are NACKed (SDA released).
- Priority rules:
  - STOP in any state: -> IDLE, o_SDA_low=0, o_busy=0 in the same cycle.
    - A frame cut short before the 8th data bit produces no o_valid, and outputs keep their old values.
  - START in any non-IDLE state (repeated start): -> ADDR, bit counter cleared, o_SDA_low=0.
  - START/STOP take priority over SCL edges detected in the same cycle.
- Read bit (W=1): treated as an address mismatch. No ACK, no SDA drive (reads are not supported).
- Reset asserted mid-frame: immediate return to reset values. The next valid frame requires a fresh START.
- o_SDA_low is never asserted while SCL=1, except during the held ACK high phase.

Test Plan:
- Full write (addr 7'h40, W, reg 8'h1A, data 8'hC3, stop) at SCL = i_clk/16:
  - o_SDA_low=1 during the 3 ACK slots.
  - o_valid is a single pulse with o_reg_addr=8'h1A and o_data=8'hC3.
  - o_busy falls SYNC_STAGES+1 cycles after SDA rises in the STOP.
- Address 7'h41:
  - o_SDA_low stays 0 for the whole frame, no o_valid, o_busy=1 until STOP.
- Address 7'h40 with R bit:
  - No ACK, no o_valid.
- STOP after reg byte 8'h05 (no data):
  - No o_valid; o_reg_addr/o_data keep prior values (8'h1A/8'hC3 from the previous test).
- Repeated START after the reg byte, then full frame reg 8'h22 / data 8'h7E:
  - One o_valid with 8'h22/8'h7E; ACKs present in the second frame.
- i_rst pulsed during the 4th data bit:
  - All outputs go to reset values within 0 cycles (async).
  - A subsequent full frame (reg 8'h10, data 8'h01) is received correctly.
